shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter and sequencer that shares one 8-bit load/set/clear register among N requesters. Each requester presents an operation (load data, set to all-ones, clear to zero) and a data byte. The block grants one requester at a time, issues exactly one control strobe toward the shared register, acknowledges the winner, then holds the grant for a programmable guard time. It sits between the requesting sub-blocks and the register's rst/set/load controls, so the register itself never sees conflicting commands.

## Interface
- N, 4, number of requesters (2..8)
- WIDTH, 8, register data width
- HOLD, 2, guard cycles the grant stays high after the issue cycle (0..15)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  N  request per requester, level; bit i = requester i
- op  in  2*N  op of requester i at bits [2i+1:2i]: 00 load, 01 set, 10 clear, 11 reserved
- data  in  WIDTH*N  data of requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i]
- grant  out  N  one-hot grant, or all zero
- ack  out  N  one-cycle completion pulse to the granted requester
- reg_load  out  1  load strobe to shared register
- reg_set  out  1  set strobe (register forced to all-ones)
- reg_clr  out  1  clear strobe (register forced to zero)
- reg_data  out  WIDTH  data accompanying the strobe
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, GUARD.
- IDLE: if req != 0 at a clock edge, select winner w = first set bit searching i = ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Latch w, op[w], data[w]. Set grant = one-hot(w). Go to ISSUE.
- ISSUE (exactly 1 cycle): assert ack[w] and exactly one strobe decoded from the latched op.
  - 00: reg_load = 1, reg_data = latched data.
  - 01: reg_set = 1, reg_data = all-ones.
  - 10: reg_clr = 1, reg_data = 0.
  - 11: no strobe. ack[w] still pulses.
  - Next state is GUARD with counter = HOLD if HOLD > 0. If HOLD = 0, go to IDLE.
- GUARD: grant held. Counter decrements each cycle. On the cycle the counter reaches 1, go to IDLE.
- Grant release: grant clears on entry to IDLE. At the same edge, ptr = (w+1) mod N.
- Requester contract: hold req and op/data stable until ack. Values are sampled only at the grant edge; later changes are ignored.
- A req dropped before being granted is never served. Dropping req after grant does not abort the transaction.
- Outputs are decoded from registered state and latched values only. There is no combinational path from inputs to outputs.
- reg_data is 0 whenever no strobe is active.

## Timing
- Reset (rst = 0, asynchronous): state IDLE, ptr = 0, grant = 0, ack = 0, all strobes 0, reg_data = 0, busy = 0. This applies immediately, including mid-transaction; an in-flight transaction is dropped with no ack and no strobe.
- Reset release: the first req is evaluated at the first rising edge with rst = 1.
- Latency: req sampled at edge k gives grant, strobe and ack high in cycle k..k+1.
- Grant width: grant stays high for 1 + HOLD cycles.
- Throughput: IDLE lasts at least 1 cycle between transactions. A continuously requesting set gives one transaction per HOLD + 2 cycles.
- Fairness: with all N requesting continuously, grants rotate 0, 1, ..., N-1, 0. No requester waits more than N-1 transactions.
- Invariants: at most one grant bit set; at most one strobe set; ack is a subset of grant; ack is never high outside ISSUE.
- Simultaneous new req and grant release at the same edge: the release edge moves to IDLE. The new req is evaluated at the following edge using the updated ptr.

## Test plan
- Reset: hold rst = 0 with req = 4'b1111. Required: all outputs 0, busy = 0. Release rst; next edge gives grant = 4'b0001 and ack[0].
- Single load: req = 4'b0100, op2 = 00, data2 = 8'hA7, HOLD = 2. Required: one cycle with reg_load = 1, reg_data = 8'hA7, ack = 4'b0100; grant high for exactly 3 cycles; busy low afterwards.
- Set/clear/reserved: requester 1 with op 01, then 10, then 11. Required: reg_set with reg_data = 8'hFF; then reg_clr with reg_data = 8'h00; then no strobe but ack[1] still pulses.
- Round-robin: req = 4'b1111 held for 8 transactions. Required: grant order 0, 1, 2, 3, 0, 1, 2, 3; consecutive issue cycles HOLD + 2 = 4 cycles apart.
- Pointer skip: after serving requester 2, set req = 4'b0101. Required: requester 0 is skipped in favour of... no: the search starts at 3, wraps past 3 to 0, so grant goes to 0, then 2 on the next transaction.
- Mid-transaction reset: assert rst = 0 during GUARD, and separately during ISSUE. Required: grant and strobes drop without waiting for a clock edge, no further ack, ptr returns to 0.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one load/set/clear register among N requesters.
// One strobe per grant, then the grant is held for HOLD guard cycles.
module shared_reg_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [2*N-1:0]     op,
  input  logic [WIDTH*N-1:0] data,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       ack,
  output logic               reg_load,
  output logic               reg_set,
  output logic               reg_clr,
  output logic [WIDTH-1:0]   reg_data,
  output logic               busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;

  state_t           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    win_q;
  logic [3:0]       cnt_q;
  logic [N-1:0]     grant_q;
  logic [N-1:0]     ack_q;
  logic             load_q;
  logic             set_q;
  logic             clr_q;
  logic [WIDTH-1:0] rdata_q;
  logic             busy_q;

  logic             found_c;
  logic [PW-1:0]    sel_c;
  logic [1:0]       sel_op_c;
  logic [WIDTH-1:0] sel_data_c;
  logic [N-1:0]     sel_onehot_c;
  logic [PW-1:0]    ptr_d;

  // Rotating priority as two passes: lowest requester at or above ptr,
  // otherwise lowest requester overall (the wrap-around part).
  always_comb begin
    found_c    = 1'b0;
    sel_c      = '0;
    sel_op_c   = '0;
    sel_data_c = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found_c && req[j] && (j >= 32'(ptr_q))) begin
        found_c    = 1'b1;
        sel_c      = PW'(j);
        sel_op_c   = op[2*j +: 2];
        sel_data_c = data[WIDTH*j +: WIDTH];
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found_c && req[j]) begin
        found_c    = 1'b1;
        sel_c      = PW'(j);
        sel_op_c   = op[2*j +: 2];
        sel_data_c = data[WIDTH*j +: WIDTH];
      end
    end
  end

  always_comb begin
    sel_onehot_c = {{(N-1){1'b0}}, 1'b1} << sel_c;
    ptr_d        = (win_q == PW'(N-1)) ? '0 : win_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      load_q  <= 1'b0;
      set_q   <= 1'b0;
      clr_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q   <= '0;
      load_q  <= 1'b0;
      set_q   <= 1'b0;
      clr_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          // Strobe and ack are registered at the grant edge so they are
          // high exactly during the ISSUE cycle.
          if (found_c) begin
            state_q <= ISSUE;
            win_q   <= sel_c;
            grant_q <= sel_onehot_c;
            ack_q   <= sel_onehot_c;
            busy_q  <= 1'b1;
            case (sel_op_c)
              2'b00: begin
                load_q  <= 1'b1;
                rdata_q <= sel_data_c;
              end
              2'b01: begin
                set_q   <= 1'b1;
                rdata_q <= '1;
              end
              2'b10: clr_q <= 1'b1;
              default: ;
            endcase
          end
        end
        ISSUE: begin
          if (HOLD == 0) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
          end else begin
            state_q <= GUARD;
            cnt_q   <= 4'(HOLD);
          end
        end
        GUARD: begin
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign reg_load = load_q;
  assign reg_set  = set_q;
  assign reg_clr  = clr_q;
  assign reg_data = rdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (N=4, WIDTH=8, HOLD=2).
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        reg_load;
  logic        reg_set;
  logic        reg_clr;
  logic [7:0]  reg_data;
  logic        busy;

  int errors = 0;
  int checks = 0;

  shared_reg_arbiter #(.N(4), .WIDTH(8), .HOLD(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .data     (data),
    .grant    (grant),
    .ack      (ack),
    .reg_load (reg_load),
    .reg_set  (reg_set),
    .reg_clr  (reg_clr),
    .reg_data (reg_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remaining two guard cycles, then the idle cycle.
  task automatic finish_txn(input string tag, input logic [3:0] g);
    tick;
    chk({tag, "_g1_ack"}, 32'(ack), 32'h0);
    chk({tag, "_g1_grant"}, 32'(grant), 32'(g));
    chk({tag, "_g1_strobes"}, {29'h0, reg_load, reg_set, reg_clr}, 32'h0);
    tick;
    chk({tag, "_g2_grant"}, 32'(grant), 32'(g));
    tick;
    chk({tag, "_idle_grant"}, 32'(grant), 32'h0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [7:0] exp_d;

    req  = 4'b1111;
    op   = 8'h00;
    data = 32'h44_33_22_11;

    // Reset with all requesting
    tick;
    tick;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_strobes", {29'h0, reg_load, reg_set, reg_clr}, 32'h0);
    chk("rst_data", 32'(reg_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    tick;
    chk("rel_grant", 32'(grant), 32'h1);
    chk("rel_ack", 32'(ack), 32'h1);
    chk("rel_load", 32'(reg_load), 32'h1);
    chk("rel_data", 32'(reg_data), 32'h11);
    chk("rel_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    finish_txn("rel", 4'b0001);

    // Single load from requester 2
    data[23:16] = 8'hA7;
    req = 4'b0100;
    tick;
    chk("ld_grant", 32'(grant), 32'h4);
    chk("ld_ack", 32'(ack), 32'h4);
    chk("ld_load", 32'(reg_load), 32'h1);
    chk("ld_setclr", {30'h0, reg_set, reg_clr}, 32'h0);
    chk("ld_data", 32'(reg_data), 32'hA7);
    req = 4'b0000;
    tick;
    chk("ld_g1_ack", 32'(ack), 32'h0);
    chk("ld_g1_grant", 32'(grant), 32'h4);
    chk("ld_g1_load", 32'(reg_load), 32'h0);
    chk("ld_g1_data", 32'(reg_data), 32'h0);
    chk("ld_g1_busy", 32'(busy), 32'h1);
    tick;
    chk("ld_g2_grant", 32'(grant), 32'h4);
    tick;
    chk("ld_idle_grant", 32'(grant), 32'h0);
    chk("ld_idle_busy", 32'(busy), 32'h0);

    // Set, clear, reserved on requester 1
    op[3:2] = 2'b01;
    req = 4'b0010;
    tick;
    chk("set_ack", 32'(ack), 32'h2);
    chk("set_strobes", {29'h0, reg_load, reg_set, reg_clr}, 32'h2);
    chk("set_data", 32'(reg_data), 32'hFF);
    req = 4'b0000;
    finish_txn("set", 4'b0010);

    op[3:2] = 2'b10;
    req = 4'b0010;
    tick;
    chk("clr_ack", 32'(ack), 32'h2);
    chk("clr_strobes", {29'h0, reg_load, reg_set, reg_clr}, 32'h1);
    chk("clr_data", 32'(reg_data), 32'h0);
    req = 4'b0000;
    finish_txn("clr", 4'b0010);

    op[3:2] = 2'b11;
    req = 4'b0010;
    tick;
    chk("rsv_ack", 32'(ack), 32'h2);
    chk("rsv_grant", 32'(grant), 32'h2);
    chk("rsv_strobes", {29'h0, reg_load, reg_set, reg_clr}, 32'h0);
    chk("rsv_data", 32'(reg_data), 32'h0);
    req = 4'b0000;
    finish_txn("rsv", 4'b0010);

    // Reset to bring the pointer back to 0, then full round-robin
    rst = 1'b0;
    tick;
    rst = 1'b1;
    op  = 8'h00;
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_g = 4'b0001 << (t % 4);
      exp_d = 8'(data >> (8 * (t % 4)));
      tick;
      chk("rr_grant", 32'(grant), 32'(exp_g));
      chk("rr_ack", 32'(ack), 32'(exp_g));
      chk("rr_data", 32'(reg_data), 32'(exp_d));
      tick;
      chk("rr_g1_ack", 32'(ack), 32'h0);
      tick;
      chk("rr_g2_grant", 32'(grant), 32'(exp_g));
      tick;
      chk("rr_idle_grant", 32'(grant), 32'h0);
      if (t == 7) req = 4'b0000;
    end

    // Pointer skip: after requester 2 the search starts at 3 and wraps to 0
    req = 4'b0100;
    tick;
    chk("skip_first", 32'(grant), 32'h4);
    req = 4'b0000;
    finish_txn("skip1", 4'b0100);
    req = 4'b0101;
    tick;
    chk("skip_wrap", 32'(grant), 32'h1);
    finish_txn("skip2", 4'b0001);
    tick;
    chk("skip_next", 32'(grant), 32'h4);
    req = 4'b0000;
    finish_txn("skip3", 4'b0100);

    // Reset during GUARD, pointer at 3 before it
    req = 4'b0010;
    tick;
    chk("grst_issue", 32'(grant), 32'h2);
    req = 4'b0000;
    tick;
    chk("grst_guard", 32'(grant), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("grst_async_grant", 32'(grant), 32'h0);
    chk("grst_async_busy", 32'(busy), 32'h0);
    tick;
    chk("grst_held_ack", 32'(ack), 32'h0);
    rst = 1'b1;
    req = 4'b1111;
    tick;
    chk("grst_ptr0", 32'(grant), 32'h1);
    chk("grst_ptr0_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    finish_txn("grst", 4'b0001);

    // Reset during ISSUE, pointer at 1 before it
    req = 4'b1000;
    tick;
    chk("irst_issue", 32'(ack), 32'h8);
    #2 rst = 1'b0;
    #1;
    chk("irst_async_grant", 32'(grant), 32'h0);
    chk("irst_async_ack", 32'(ack), 32'h0);
    chk("irst_async_load", 32'(reg_load), 32'h0);
    chk("irst_async_data", 32'(reg_data), 32'h0);
    chk("irst_async_busy", 32'(busy), 32'h0);
    tick;
    chk("irst_held_grant", 32'(grant), 32'h0);
    rst = 1'b1;
    req = 4'b1111;
    tick;
    chk("irst_ptr0", 32'(grant), 32'h1);
    req = 4'b0000;
    finish_txn("irst", 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
